// File: rtl/riscv_xc_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// riscv_xc_init_ctrl_pkg : XC bank constants and init sequencer state encoding
// Revision: 1.0   Option macro: XC_INIT_READBACK_EN
// ============================================================================
package riscv_xc_init_ctrl_pkg;

    localparam int XC_BANK_BIT = 6;
    localparam logic [XC_BANK_BIT:0] XC_BASE_ADDR = (XC_BANK_BIT + 1)'(1) << XC_BANK_BIT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
`ifdef XC_INIT_READBACK_EN
        CHECK = 2'd2,
`endif
        DONE  = 2'd3
    } xc_init_state_e;

endpackage : riscv_xc_init_ctrl_pkg
`default_nettype wire

// File: rtl/riscv_xc_init_ctrl.sv
`default_nettype none
// ============================================================================
// riscv_xc_init_ctrl : xc.init sequencer, zeroes the XC register bank through
//                      write port B and optionally reads it back via port C.
// Revision: 1.0   Option macro: XC_INIT_READBACK_EN (adds CHECK readback pass)
// ============================================================================
module riscv_xc_init_ctrl
    import riscv_xc_init_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_XC_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req_i,
    output logic                  init_ack_o,
    output logic                  busy_o,
    input  logic                  flush_i,
    input  logic                  pipe_we_i,
`ifdef XC_INIT_READBACK_EN
    input  logic                  pipe_re_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  err_o,
`endif
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o
);

    localparam int              IDX_W    = $clog2(NUM_XC_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_XC_WORDS - 1);

    xc_init_state_e        state;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] xc_addr;
    logic                  clear_slot;

    assign xc_addr = ADDR_WIDTH'(XC_BASE_ADDR) | ADDR_WIDTH'(idx);

    // The pipeline always wins port B; a flush cancels the slot it lands on.
    assign clear_slot = (state == CLEAR) && !pipe_we_i && !flush_i;
    assign rf_we_o    = clear_slot;
    assign rf_waddr_o = clear_slot ? xc_addr : '0;
    assign rf_wdata_o = '0;

`ifdef XC_INIT_READBACK_EN
    logic check_slot;
    assign check_slot = (state == CHECK) && !pipe_re_i && !flush_i;
    assign rf_raddr_o = check_slot ? xc_addr : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            init_ack_o <= 1'b0;
            busy_o     <= 1'b0;
`ifdef XC_INIT_READBACK_EN
            err_o      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (init_req_i) begin
                        state  <= CLEAR;
                        idx    <= '0;
                        busy_o <= 1'b1;
`ifdef XC_INIT_READBACK_EN
                        err_o  <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        idx    <= '0;
                        busy_o <= 1'b0;
                    end else if (!pipe_we_i) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
`ifdef XC_INIT_READBACK_EN
                            state      <= CHECK;
`else
                            state      <= DONE;
                            busy_o     <= 1'b0;
                            init_ack_o <= 1'b1;
`endif
                        end
                    end
                end
`ifdef XC_INIT_READBACK_EN
                CHECK: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        idx    <= '0;
                        busy_o <= 1'b0;
                    end else if (!pipe_re_i) begin
                        idx <= idx + 1'b1;
                        if (rf_rdata_i != '0) begin
                            err_o <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state      <= DONE;
                            busy_o     <= 1'b0;
                            init_ack_o <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    // Four-phase handshake: ack drops on the edge that sees req low.
                    if (!init_req_i) begin
                        state      <= IDLE;
                        init_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    busy_o     <= 1'b0;
                    init_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : riscv_xc_init_ctrl
`default_nettype wire

// File: tb/tb_riscv_xc_init_ctrl.sv
`default_nettype none
// ============================================================================
// tb_riscv_xc_init_ctrl : randomized scoreboard bench for the xc.init sequencer
// Revision: 1.0   Option macro: XC_INIT_READBACK_EN
// ============================================================================
module tb_riscv_xc_init_ctrl;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_req = 1'b0;
    logic          init_ack;
    logic          busy;
    logic          flush = 1'b0;
    logic          pipe_we = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef XC_INIT_READBACK_EN
    logic          pipe_re = 1'b0;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata = '0;
    logic          err;
`endif

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_xc_init_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_XC_WORDS(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req_i (init_req),
        .init_ack_o (init_ack),
        .busy_o     (busy),
        .flush_i    (flush),
        .pipe_we_i  (pipe_we),
`ifdef XC_INIT_READBACK_EN
        .pipe_re_i  (pipe_re),
        .rf_raddr_o (rf_raddr),
        .rf_rdata_i (rf_rdata),
        .err_o      (err),
`endif
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every granted write must match the next expected XC address.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pipe_we) check("we_while_pipe_owns_port", {31'd0, rf_we}, 32'd0);
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {25'd0, rf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", {25'd0, rf_waddr}, {25'd0, exp_q.pop_front()});
                    check("write_data", rf_wdata, 32'd0);
                end
            end
`ifdef XC_INIT_READBACK_EN
            if (!busy) check("raddr_idle_zero", {25'd0, rf_raddr}, 32'd0);
`endif
        end
    end

    task automatic check_all_reset();
        check("rst_ack", {31'd0, init_ack}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_we", {31'd0, rf_we}, 0);
        check("rst_waddr", {25'd0, rf_waddr}, 0);
        check("rst_wdata", rf_wdata, 0);
`ifdef XC_INIT_READBACK_EN
        check("rst_raddr", {25'd0, rf_raddr}, 0);
        check("rst_err", {31'd0, err}, 0);
`endif
    endtask

    // stall_pct < 0 selects the fixed stall window on cycles 3..5 of CLEAR.
    // Enters and leaves 1 time unit after a rising edge.
    task automatic run_init(input int stall_pct, input int flush_at, input int bad_idx, input int rst_at);
        int  writes;
        int  c;
        bit  stall;
        bit  fl;
        for (int i = 0; i < NW; i++) begin
            if ((flush_at < 0 || i < flush_at) && (rst_at < 0 || i < rst_at))
                exp_q.push_back(AW'(7'h40 + i));
        end
        init_req = 1'b1;
        @(posedge clk); #1;
        writes = 0;
        c = 0;
        while (writes < NW && c < 300) begin
            if (writes == rst_at) begin
                #1 rst_n = 1'b0;
                #1 check_all_reset();
                exp_q.delete();
                init_req = 1'b0;
                pipe_we  = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
                @(posedge clk); #1;
                check("post_rst_ack", {31'd0, init_ack}, 0);
                check("post_rst_busy", {31'd0, busy}, 0);
                return;
            end
            stall   = (stall_pct < 0) ? (c >= 3 && c <= 5) : ($urandom_range(0, 99) < stall_pct);
            fl      = (writes == flush_at) && !stall;
            pipe_we = stall;
            flush   = fl;
            @(negedge clk);
            check("clear_busy", {31'd0, busy}, 1);
            check("clear_ack", {31'd0, init_ack}, 0);
`ifdef XC_INIT_READBACK_EN
            check("clear_raddr_zero", {25'd0, rf_raddr}, 0);
            if (c == 0) check("err_cleared_on_req", {31'd0, err}, 0);
`endif
            @(posedge clk); #1;
            c++;
            if (fl) begin
                flush    = 1'b0;
                init_req = 1'b0;
                check("flush_ack", {31'd0, init_ack}, 0);
                check("flush_busy", {31'd0, busy}, 0);
                check("flush_pending_writes", exp_q.size(), 0);
                @(posedge clk); #1;
                return;
            end
            if (!stall) writes++;
        end
        pipe_we = 1'b0;
        check("clear_complete", writes, NW);
`ifdef XC_INIT_READBACK_EN
        writes = 0;
        c = 0;
        while (writes < NW && c < 300) begin
            stall    = (stall_pct < 0) ? 1'b0 : ($urandom_range(0, 99) < stall_pct);
            pipe_re  = stall;
            rf_rdata = stall ? $urandom : ((writes == bad_idx) ? 32'hDEAD_BEEF : 32'd0);
            @(negedge clk);
            check("check_busy", {31'd0, busy}, 1);
            if (!stall) check("check_raddr", {25'd0, rf_raddr}, 32'h40 + writes);
            @(posedge clk); #1;
            c++;
            if (!stall) writes++;
        end
        pipe_re  = 1'b0;
        rf_rdata = '0;
`endif
        check("ack_on_done", {31'd0, init_ack}, 1);
        check("busy_on_done", {31'd0, busy}, 0);
        // Request held: stays in DONE, flush ignored, no further writes.
        for (int k = 0; k < 3; k++) begin
            flush = (k == 1);
            @(negedge clk);
            check("ack_held", {31'd0, init_ack}, 1);
            @(posedge clk); #1;
        end
        flush = 1'b0;
`ifdef XC_INIT_READBACK_EN
        check("err_sticky", {31'd0, err}, (bad_idx >= 0) ? 1 : 0);
`endif
        init_req = 1'b0;
        @(posedge clk); #1;
        check("ack_release", {31'd0, init_ack}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("all_writes_seen", exp_q.size(), 0);
    endtask

    initial begin
        #12;
        check_all_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_init(0, -1, -1, -1);
        run_init(-1, -1, 5, -1);
        run_init(0, 7, -1, -1);
        run_init(0, -1, -1, -1);
        run_init(0, -1, -1, 9);
        for (int r = 0; r < 4; r++) begin
            run_init(30, -1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1, -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_riscv_xc_init_ctrl
`default_nettype wire
